// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser fed by a first-word-fall-through endpoint fifo.
// Pops x0,y0,x1,y1 for each line and emits one pixel per accepted handshake.
module line_raster_engine #(
    parameter int COORD_W = 11
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [COORD_W-1:0] i_fifo_data,
    input  logic               i_fifo_empty,
    output logic               o_fifo_read,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic               o_pix_valid,
    input  logic               i_pix_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int ERR_W = COORD_W + 2;
    localparam int E2_W  = COORD_W + 3;
    localparam logic signed [ERR_W-1:0] ERR_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        DRAW,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]                cnt;
    logic [COORD_W-1:0]        x0;
    logic [COORD_W-1:0]        y0;
    logic [COORD_W-1:0]        x1;
    logic [COORD_W-1:0]        y1;
    logic [COORD_W-1:0]        cur_x;
    logic [COORD_W-1:0]        cur_y;
    logic signed [ERR_W-1:0]   dx;
    logic signed [ERR_W-1:0]   dy;
    logic signed [ERR_W-1:0]   err;
    logic signed [ERR_W-1:0]   err_next;
    logic signed [ERR_W-1:0]   diff_x;
    logic signed [ERR_W-1:0]   diff_y;
    logic signed [1:0]         sx;
    logic signed [1:0]         sy;
    logic signed [E2_W-1:0]    e2;
    logic signed [E2_W-1:0]    dx_ext;
    logic signed [E2_W-1:0]    dy_ext;
    logic                      step_x;
    logic                      step_y;
    logic                      accept;
    logic                      at_end;

    function automatic logic signed [ERR_W-1:0] coord_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        return $signed({2'b00, a}) - $signed({2'b00, b});
    endfunction

    function automatic logic signed [ERR_W-1:0] abs_val(
        input logic signed [ERR_W-1:0] v
    );
        return (v < 0) ? -v : v;
    endfunction

    // Apply a +1/-1 step; modular add is safe since the walk never leaves the endpoint box.
    function automatic logic [COORD_W-1:0] coord_step(
        input logic [COORD_W-1:0] c,
        input logic signed [1:0]  s
    );
        return c + {{(COORD_W-2){s[1]}}, s};
    endfunction

    assign o_fifo_read = i_reset && !i_fifo_empty && ((state == IDLE) || (state == FETCH));
    assign o_pix_valid = (state == DRAW);
    assign o_pix_x     = cur_x;
    assign o_pix_y     = cur_y;
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);

    assign accept = (state == DRAW) && i_pix_ready;
    assign at_end = (cur_x == x1) && (cur_y == y1);

    assign diff_x = coord_diff(x1, x0);
    assign diff_y = coord_diff(y1, y0);

    // Both step decisions look at the error term from before this cycle's update.
    assign e2     = {err, 1'b0};
    assign dx_ext = {dx[ERR_W-1], dx};
    assign dy_ext = {dy[ERR_W-1], dy};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);
    assign err_next = err + (step_x ? dy : ERR_ZERO) + (step_y ? dx : ERR_ZERO);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (o_fifo_read) state_next = FETCH;
            FETCH:   if (o_fifo_read && (cnt == 2'd3)) state_next = SETUP;
            SETUP:   state_next = DRAW;
            DRAW:    if (accept && at_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt   <= 2'd0;
            x0    <= '0;
            y0    <= '0;
            x1    <= '0;
            y1    <= '0;
            cur_x <= '0;
            cur_y <= '0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            sx    <= '0;
            sy    <= '0;
        end else begin
            // Word counter wraps back to 0 after y1, ready for the next line.
            if (o_fifo_read) begin
                case (cnt)
                    2'd0: x0 <= i_fifo_data;
                    2'd1: y0 <= i_fifo_data;
                    2'd2: x1 <= i_fifo_data;
                    2'd3: y1 <= i_fifo_data;
                endcase
                cnt <= cnt + 2'd1;
            end

            if (state == SETUP) begin
                dx    <= abs_val(diff_x);
                dy    <= -abs_val(diff_y);
                err   <= abs_val(diff_x) - abs_val(diff_y);
                sx    <= (x0 < x1) ? 2'sd1 : -2'sd1;
                sy    <= (y0 < y1) ? 2'sd1 : -2'sd1;
                cur_x <= x0;
                cur_y <= y0;
            end

            if (accept && !at_end) begin
                if (step_x) cur_x <= coord_step(cur_x, sx);
                if (step_y) cur_y <= coord_step(cur_y, sy);
                err <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed and randomized checks of line_raster_engine against a queue-based
// Bresenham reference model and a simple fifo model.
module tb_line_raster_engine;

    localparam int COORD_W = 11;

    logic               clk = 1'b0;
    logic               i_reset;
    logic [COORD_W-1:0] i_fifo_data;
    logic               i_fifo_empty;
    logic               o_fifo_read;
    logic [COORD_W-1:0] o_pix_x;
    logic [COORD_W-1:0] o_pix_y;
    logic               o_pix_valid;
    logic               i_pix_ready;
    logic               o_busy;
    logic               o_done;

    int n_vec = 0;
    int n_err = 0;
    int exp_pops = 0;

    logic [COORD_W-1:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int pops = 0;

    int ex[$];
    int ey[$];

    always #5 clk = ~clk;

    line_raster_engine #(.COORD_W(COORD_W)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_fifo_data (i_fifo_data),
        .i_fifo_empty(i_fifo_empty),
        .o_fifo_read (o_fifo_read),
        .o_pix_x     (o_pix_x),
        .o_pix_y     (o_pix_y),
        .o_pix_valid (o_pix_valid),
        .i_pix_ready (i_pix_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    assign i_fifo_data  = mem[rd_ptr % 256];
    assign i_fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_fifo_read) begin
            rd_ptr       <= rd_ptr + 1;
            pops         <= pops + 1;
            last_pop_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int v);
        mem[wr_ptr % 256] = v[COORD_W-1:0];
        wr_ptr++;
    endtask

    task automatic push_line(input int x0, input int y0, input int x1, input int y1);
        push(x0); push(y0); push(x1); push(y1);
        exp_pops += 4;
    endtask

    // Reference walk on plain integers.
    function automatic void build_expected(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        ex.delete();
        ey.delete();
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        forever begin
            ex.push_back(x);
            ey.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    // mode 0: always ready, 1: random ready, 2: stall 3 cycles on pixel index 1.
    // reset_at >= 0 pulses reset while that pixel index is presented.
    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int mode, input int reset_at);
        int idx, held, budget;
        bit first, done_wait, finished, rdy;
        build_expected(x0, y0, x1, y1);
        idx = 0; held = 0; first = 1; done_wait = 0; finished = 0;
        budget = ex.size() * 8 + 60;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            check("rd_while_empty", 32'(o_fifo_read && i_fifo_empty), 0);
            if (done_wait) begin
                check("done_pulse", 32'(o_done), 1);
                check("done_valid", 32'(o_pix_valid), 0);
                @(negedge clk);
                check("done_one_cycle", 32'(o_done), 0);
                check("busy_after_done", 32'(o_busy), 0);
                finished = 1;
            end else if (o_pix_valid) begin
                if (first) begin
                    check("first_pix_latency", 32'(cyc - last_pop_cyc), 2);
                    first = 0;
                end
                check("pix_x", 32'(o_pix_x), 32'(ex[idx]));
                check("pix_y", 32'(o_pix_y), 32'(ey[idx]));
                check("no_pop_in_draw", 32'(o_fifo_read), 0);
                check("no_done_in_draw", 32'(o_done), 0);
                if (idx == reset_at) begin
                    i_reset = 1'b0;
                    @(negedge clk);
                    check("rst_valid", 32'(o_pix_valid), 0);
                    check("rst_x", 32'(o_pix_x), 0);
                    check("rst_y", 32'(o_pix_y), 0);
                    check("rst_busy", 32'(o_busy), 0);
                    check("rst_done", 32'(o_done), 0);
                    check("rst_read", 32'(o_fifo_read), 0);
                    i_reset = 1'b1;
                    finished = 1;
                end else begin
                    if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
                    else if (mode == 2 && idx == 1 && held < 3) begin rdy = 0; held++; end
                    else rdy = 1;
                    i_pix_ready = rdy;
                    if (rdy) begin
                        idx++;
                        if (idx == ex.size()) done_wait = 1;
                    end
                end
            end else if (!first) begin
                check("valid_dropped_mid_line", 32'(o_pix_valid), 1);
            end
        end
        if (!finished) check("line_timeout", 0, 1);
        i_pix_ready = 1'b1;
    endtask

    initial begin
        int x0, y0, x1, y1;
        i_reset     = 1'b0;
        i_pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(o_pix_valid), 0);
        check("reset_x", 32'(o_pix_x), 0);
        check("reset_y", 32'(o_pix_y), 0);
        check("reset_busy", 32'(o_busy), 0);
        check("reset_done", 32'(o_done), 0);
        check("reset_read", 32'(o_fifo_read), 0);
        i_reset = 1'b1;
        @(negedge clk);
        check("idle_empty_read", 32'(o_fifo_read), 0);

        push_line(0, 0, 3, 0);
        run_line(0, 0, 3, 0, 0, -1);
        check("pops_horizontal", 32'(pops), 32'(exp_pops));

        push_line(0, 0, 1, 3);
        push_line(5, 5, 5, 5);
        run_line(0, 0, 1, 3, 0, -1);
        run_line(5, 5, 5, 5, 0, -1);
        check("pops_steep_point", 32'(pops), 32'(exp_pops));

        push_line(2047, 2047, 2044, 2044);
        run_line(2047, 2047, 2044, 2044, 0, -1);

        push_line(0, 0, 3, 0);
        run_line(0, 0, 3, 0, 2, -1);

        push(0); push(0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("underrun_no_read", 32'(o_fifo_read), 0);
            check("underrun_busy", 32'(o_busy), 1);
            check("underrun_no_valid", 32'(o_pix_valid), 0);
        end
        push(4); push(1);
        exp_pops += 4;
        run_line(0, 0, 4, 1, 0, -1);
        check("pops_underrun", 32'(pops), 32'(exp_pops));

        push_line(0, 0, 3, 0);
        run_line(0, 0, 3, 0, 0, 2);
        repeat (2) begin
            @(negedge clk);
            check("post_reset_quiet_valid", 32'(o_pix_valid), 0);
            check("post_reset_quiet_done", 32'(o_done), 0);
        end
        push_line(7, 2, 3, 9);
        run_line(7, 2, 3, 9, 1, -1);

        for (int n = 0; n < 12; n++) begin
            x0 = $urandom_range(0, 2047);
            y0 = $urandom_range(0, 2047);
            x1 = x0 + $urandom_range(0, 40) - 20;
            y1 = y0 + $urandom_range(0, 40) - 20;
            if (x1 < 0) x1 = 0;
            if (x1 > 2047) x1 = 2047;
            if (y1 < 0) y1 = 0;
            if (y1 > 2047) y1 = 2047;
            push_line(x0, y0, x1, y1);
            run_line(x0, y0, x1, y1, 1, -1);
        end
        check("pops_total", 32'(pops), 32'(exp_pops));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_raster_engine.md
Name: line_raster_engine

Overview:
- Consumer stage directly downstream of the 11-bit endpoint fifo in the line-drawing path.
- Pops four coordinate words per line (x0, y0, x1, y1) and runs an integer Bresenham walk.
- Emits one pixel coordinate per cycle to the frame-buffer writer over a valid/ready handshake.
- Runs continuously, taking line after line while the fifo holds data.

Parameters:
COORD_W, 11, width of each coordinate word and pixel output; internal err is COORD_W+2 signed, e2 is COORD_W+3 signed

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous reset, active-low (0 = reset, sampled on i_clk rising edge)
i_fifo_data  input  COORD_W  head word of upstream fifo (first-word-fall-through, valid whenever i_fifo_empty=0)
i_fifo_empty  input  1  upstream fifo empty flag
o_fifo_read  output  1  pop strobe; one word consumed per cycle it is high
o_pix_x  output  COORD_W  pixel x
o_pix_y  output  COORD_W  pixel y
o_pix_valid  output  1  pixel outputs valid
i_pix_ready  input  1  downstream accepts pixel this cycle when high with o_pix_valid
o_busy  output  1  high in any state other than IDLE
o_done  output  1  one-cycle pulse after last pixel of a line is accepted

Behaviour:
- Reset (i_reset=0 at clock edge): state=IDLE; o_fifo_read=0, o_pix_valid=0, o_pix_x=0, o_pix_y=0, o_busy=0, o_done=0; word counter, err, sx, sy cleared. Reset mid-line abandons the line: no further pixels, no o_done, no pops.
- o_fifo_read is combinational: (state==IDLE or FETCH) and i_fifo_empty=0. It is never high while i_fifo_empty=1.
- IDLE: on the first non-empty cycle, pop word 0 (x0) and go to FETCH with cnt=1.
- FETCH: latch i_fifo_data into x0/y0/x1/y1 by cnt on each pop.
  - If the fifo goes empty mid-fetch, the block stalls with no pop and holds cnt.
  - After the pop with cnt=3, go to SETUP.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=-|y1-y0|.
  - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1.
  - err=dx+dy; cur_x=x0, cur_y=y0.
  - Go to DRAW.
- DRAW:
  - o_pix_valid=1, o_pix_x=cur_x, o_pix_y=cur_y.
  - Outputs are held stable while i_pix_ready=0.
  - On accept (valid & ready):
    - If cur_x==x1 and cur_y==y1, go to DONE.
    - Otherwise e2=2*err:
      - x step: if e2>=dy, cur_x+=sx and add dy to err.
      - y step: if e2<=dx, cur_y+=sy and add dx to err.
      - Both comparisons use the pre-update err; both steps may occur in the same cycle.
- DONE (1 cycle): o_done=1, o_pix_valid=0, then return to IDLE. The next line's x0 is not popped in DONE.
- Throughput and latency:
  - With i_pix_ready held high, a line emits max(|dx|,|-dy|)+1 pixels on consecutive cycles.
  - First o_pix_valid appears 2 cycles after the cycle of the 4th pop (SETUP, then DRAW).
- Degenerate line (x0==x1, y0==y1): exactly one pixel, then DONE.
- Arithmetic:
  - All subtraction is on zero-extended unsigned coordinates into COORD_W+2 signed.
  - Coordinates never wrap, because Bresenham terminates at the endpoint and stays within [min,max] of the endpoints.
- No pops occur during SETUP, DRAW or DONE; words for the next line stay in the fifo.

Test Plan:
- Horizontal: fifo holds 0,0,3,0, ready=1 -> 4 pops on consecutive cycles; pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles starting 2 cycles after the 4th pop; o_done one cycle after (3,0) accepted; o_busy low next cycle.
- Steep plus single-point: fifo holds 0,0,1,3 then 5,5,5,5 -> first line gives (0,0),(0,1),(1,2),(1,3) then o_done; second line gives exactly (5,5) then o_done; 8 pops total.
- Reverse diagonal at the limit: 2047,2047,2044,2044 -> (2047,2047),(2046,2046),(2045,2045),(2044,2044); sx=sy=-1; no wrap.
- Backpressure: line 0,0,3,0 with i_pix_ready=0 for 3 cycles while (1,0) is presented -> o_pix_x=1, o_pix_y=0 and o_pix_valid=1 held all 3 cycles; no skipped or duplicated pixels.
- Fifo underrun: only 2 words present (x0=0, y0=0), then empty for 5 cycles, then 4,1 written -> o_fifo_read low during the empty gap, cnt holds; line (0,0)->(4,1) yields (0,0),(1,0),(2,0)? exact: (0,0),(1,0),(2,1),(3,1),(4,1).
- Reset mid-line: i_reset=0 for one cycle while (2,0) of line 0,0,3,0 is presented -> next cycle all outputs 0, state IDLE, no o_done; the next line in the fifo is drawn correctly afterwards.
